// File: rtl/parking_gate_scheduler.sv
// parking_gate_scheduler: round-robin owner of a shared parking barrier with occupancy tracking
module parking_gate_scheduler #(
    parameter logic [7:0]  CAPACIDAD = 8'd50,
    parameter logic [15:0] TIMEOUT   = 16'd1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_entrada,
    input  logic       req_salida,
    input  logic       sensor_paso,
    output logic       compuerta_abrir,
    output logic       grant_entrada,
    output logic       grant_salida,
    output logic [7:0] ocupacion,
    output logic       lleno,
    output logic       vacio,
    output logic       alarma_timeout
);
    typedef enum logic [2:0] {IDLE, ABIERTA_ENT, ABIERTA_SAL, PASANDO, ALARMA} state_t;

    state_t      state_q, state_d;
    logic [7:0]  ocupacion_q, ocupacion_d;
    logic [15:0] timer_q, timer_d;
    logic        ultimo_salida_q, ultimo_salida_d;
    logic        sensor_prev_q, sensor_prev_d;
    logic        salida, paso, expira, eleg_ent, eleg_sal;

    assign lleno    = ocupacion_q == CAPACIDAD;
    assign vacio    = ocupacion_q == 8'd0;
    assign eleg_ent = req_entrada && !lleno;
    assign eleg_sal = req_salida && !vacio;
    assign salida   = state_q == ABIERTA_SAL;
    assign paso     = sensor_paso && !sensor_prev_q;
    assign expira   = timer_q == TIMEOUT - 16'd1;

    // Moore outputs; in PASANDO the served lane is the one just recorded in ultimo_salida
    assign compuerta_abrir = state_q == ABIERTA_ENT || state_q == ABIERTA_SAL || state_q == PASANDO;
    assign grant_entrada   = state_q == ABIERTA_ENT || (state_q == PASANDO && !ultimo_salida_q);
    assign grant_salida    = state_q == ABIERTA_SAL || (state_q == PASANDO && ultimo_salida_q);
    assign alarma_timeout  = state_q == ALARMA;
    assign ocupacion       = ocupacion_q;

    // Next state: arbitration in IDLE, pass/timeout resolution while open, hold while a vehicle is under the bar
    always_comb begin
        state_d         = state_q;
        ocupacion_d     = ocupacion_q;
        timer_d         = '0;
        ultimo_salida_d = ultimo_salida_q;
        sensor_prev_d   = sensor_paso;
        case (state_q)
            IDLE: begin
                if (eleg_ent && eleg_sal) state_d = ultimo_salida_q ? ABIERTA_ENT : ABIERTA_SAL;
                else if (eleg_ent)        state_d = ABIERTA_ENT;
                else if (eleg_sal)        state_d = ABIERTA_SAL;
            end
            ABIERTA_ENT, ABIERTA_SAL: begin
                if (paso) begin
                    state_d         = PASANDO;
                    ultimo_salida_d = salida;
                    ocupacion_d     = salida ? (vacio ? ocupacion_q : ocupacion_q - 8'd1)
                                             : (lleno ? ocupacion_q : ocupacion_q + 8'd1);
                end else if (expira) begin
                    state_d         = ALARMA;
                    ultimo_salida_d = salida;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            PASANDO: state_d = sensor_paso ? PASANDO : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset clears everything and hands the first tie to the entry lane
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            ocupacion_q     <= '0;
            timer_q         <= '0;
            ultimo_salida_q <= 1'b1;
            sensor_prev_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            ocupacion_q     <= ocupacion_d;
            timer_q         <= timer_d;
            ultimo_salida_q <= ultimo_salida_d;
            sensor_prev_q   <= sensor_prev_d;
        end
    end
endmodule

// File: tb/tb_parking_gate_scheduler.sv
// tb_parking_gate_scheduler: directed checks of the barrier scheduler (large lot and a 2-space lot)
module tb_parking_gate_scheduler;
    logic clock, reset, req_entrada, req_salida, sensor_paso;
    logic a_abrir, a_ge, a_gs, a_lleno, a_vacio, a_alarma;
    logic b_abrir, b_ge, b_gs, b_lleno, b_vacio, b_alarma;
    logic [7:0] a_ocup, b_ocup;
    int n_vec = 0;
    int n_err = 0;

    parking_gate_scheduler #(.CAPACIDAD(8'd50), .TIMEOUT(16'd8)) u_a (
        .clock(clock), .reset(reset), .req_entrada(req_entrada), .req_salida(req_salida),
        .sensor_paso(sensor_paso), .compuerta_abrir(a_abrir), .grant_entrada(a_ge),
        .grant_salida(a_gs), .ocupacion(a_ocup), .lleno(a_lleno), .vacio(a_vacio),
        .alarma_timeout(a_alarma)
    );

    parking_gate_scheduler #(.CAPACIDAD(8'd2), .TIMEOUT(16'd8)) u_b (
        .clock(clock), .reset(reset), .req_entrada(req_entrada), .req_salida(req_salida),
        .sensor_paso(sensor_paso), .compuerta_abrir(b_abrir), .grant_entrada(b_ge),
        .grant_salida(b_gs), .ocupacion(b_ocup), .lleno(b_lleno), .vacio(b_vacio),
        .alarma_timeout(b_alarma)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req_entrada = 1'b0;
        req_salida = 1'b0;
        sensor_paso = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic pasar_ent;
        req_entrada = 1'b1;
        tick();
        req_entrada = 1'b0;
        sensor_paso = 1'b1;
        tick();
        sensor_paso = 1'b0;
        tick();
    endtask

    task automatic pasar_sal;
        req_salida = 1'b1;
        tick();
        req_salida = 1'b0;
        sensor_paso = 1'b1;
        tick();
        sensor_paso = 1'b0;
        tick();
    endtask

    initial begin
        // reset values
        do_reset();
        chk("rst_abrir", a_abrir, 0);
        chk("rst_ge", a_ge, 0);
        chk("rst_gs", a_gs, 0);
        chk("rst_ocup", a_ocup, 0);
        chk("rst_vacio", a_vacio, 1);
        chk("rst_lleno", a_lleno, 0);
        chk("rst_alarma", a_alarma, 0);

        // single entry with a pass three cycles after the request
        req_entrada = 1'b1;
        tick();
        chk("ent_grant", a_ge, 1);
        chk("ent_abrir", a_abrir, 1);
        chk("ent_gs", a_gs, 0);
        req_entrada = 1'b0;
        tick();
        tick();
        sensor_paso = 1'b1;
        tick();
        chk("ent_paso_ocup", a_ocup, 1);
        chk("ent_paso_abrir", a_abrir, 1);
        chk("ent_paso_ge", a_ge, 1);
        sensor_paso = 1'b0;
        tick();
        chk("ent_close", a_abrir, 0);
        chk("ent_close_ge", a_ge, 0);
        chk("ent_vacio", a_vacio, 0);

        // reach 5 vehicles with the exit lane served last, then contend
        do_reset();
        repeat (6) pasar_ent();
        pasar_sal();
        chk("rr_setup_ocup", a_ocup, 5);
        req_entrada = 1'b1;
        req_salida = 1'b1;
        tick();
        chk("rr1_ge", a_ge, 1);
        chk("rr1_gs", a_gs, 0);
        req_entrada = 1'b0;
        sensor_paso = 1'b1;
        tick();
        chk("rr1_ocup", a_ocup, 6);
        chk("rr1_pas_gs", a_gs, 0);
        sensor_paso = 1'b0;
        tick();
        chk("rr1_idle_abrir", a_abrir, 0);
        req_entrada = 1'b1;
        tick();
        chk("rr2_gs", a_gs, 1);
        chk("rr2_ge", a_ge, 0);
        req_entrada = 1'b0;
        req_salida = 1'b0;
        sensor_paso = 1'b1;
        tick();
        chk("rr2_ocup", a_ocup, 5);
        chk("rr2_pas_ge", a_ge, 0);
        sensor_paso = 1'b0;
        tick();
        chk("rr2_idle_gs", a_gs, 0);

        // exit grant with no vehicle: eight open cycles then a single alarm pulse
        do_reset();
        pasar_ent();
        req_salida = 1'b1;
        tick();
        chk("to_gs", a_gs, 1);
        req_salida = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("to_open", {a_abrir, a_gs, a_alarma}, 3'b110);
        end
        tick();
        chk("to_alarma", a_alarma, 1);
        chk("to_abrir", a_abrir, 0);
        chk("to_grants", {a_ge, a_gs}, 0);
        chk("to_ocup", a_ocup, 1);
        tick();
        chk("to_alarma_end", a_alarma, 0);
        chk("to_ocup_end", a_ocup, 1);

        // pass on the last cycle before timeout still counts
        req_entrada = 1'b1;
        tick();
        req_entrada = 1'b0;
        repeat (7) tick();
        sensor_paso = 1'b1;
        tick();
        chk("late_pass_alarma", a_alarma, 0);
        chk("late_pass_ocup", a_ocup, 2);
        chk("late_pass_abrir", a_abrir, 1);
        sensor_paso = 1'b0;
        tick();

        // sensor already high at grant is not a pass; a fresh edge is; reset aborts PASANDO
        do_reset();
        sensor_paso = 1'b1;
        req_entrada = 1'b1;
        tick();
        req_entrada = 1'b0;
        chk("held_grant", a_ge, 1);
        tick();
        chk("held_nocount", a_ocup, 0);
        chk("held_open", a_abrir, 1);
        sensor_paso = 1'b0;
        tick();
        sensor_paso = 1'b1;
        tick();
        chk("fresh_count", a_ocup, 1);
        reset = 1'b1;
        #1;
        chk("async_abrir", a_abrir, 0);
        chk("async_ge", a_ge, 0);
        chk("async_ocup", a_ocup, 0);
        chk("async_vacio", a_vacio, 1);
        chk("async_alarma", a_alarma, 0);
        sensor_paso = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_abrir", a_abrir, 0);

        // 2-space lot: full blocks entry, exit still served, entry resumes afterwards
        do_reset();
        pasar_ent();
        pasar_ent();
        chk("cap_ocup", b_ocup, 2);
        chk("cap_lleno", b_lleno, 1);
        req_entrada = 1'b1;
        tick();
        chk("cap_no_grant", {b_abrir, b_ge}, 0);
        req_salida = 1'b1;
        tick();
        chk("cap_gs", b_gs, 1);
        chk("cap_ge", b_ge, 0);
        req_salida = 1'b0;
        sensor_paso = 1'b1;
        tick();
        chk("cap_exit_ocup", b_ocup, 1);
        chk("cap_exit_lleno", b_lleno, 0);
        sensor_paso = 1'b0;
        tick();
        tick();
        chk("cap_ent_resume", b_ge, 1);
        req_entrada = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/parking_gate_scheduler.md
PARKING_GATE_SCHEDULER -- requirements
Module: parking_gate_scheduler

Interface
REQ-001 Parameter CAPACIDAD, default 8'd50, maximum vehicles inside the lot.
REQ-002 Parameter TIMEOUT, default 16'd1000, clock cycles a granted gate waits for a vehicle before aborting.
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 req_entrada  input  1  entry-lane access controller requests the shared barrier (level, held until granted).
REQ-006 req_salida  input  1  exit-lane reader requests the shared barrier (level, held until granted).
REQ-007 sensor_paso  input  1  vehicle-under-barrier sensor, high while a vehicle occupies the gate.
REQ-008 compuerta_abrir  output  1  barrier open command.
REQ-009 grant_entrada  output  1  entry lane currently owns the barrier.
REQ-010 grant_salida  output  1  exit lane currently owns the barrier.
REQ-011 ocupacion  output  8  vehicles currently inside.
REQ-012 lleno  output  1  high when ocupacion == CAPACIDAD.
REQ-013 vacio  output  1  high when ocupacion == 0.
REQ-014 alarma_timeout  output  1  one-cycle pulse when a grant expires without a vehicle passing.

Function
REQ-015 FSM states: IDLE, ABIERTA_ENT, ABIERTA_SAL, PASANDO, ALARMA; all outputs decoded from registered state/counters (Moore).
REQ-016 Eligibility: entry eligible = req_entrada && !lleno; exit eligible = req_salida && !vacio.
REQ-017 IDLE: one eligible lane -> go to its ABIERTA state next edge; none -> stay IDLE.
REQ-018 IDLE, both eligible: grant the lane not served last (round-robin register ultimo_salida; reset value 1, so entry wins the first tie).
REQ-019 ABIERTA_ENT/ABIERTA_SAL: compuerta_abrir=1, matching grant=1, other grant=0; timer counts up from 0 each cycle.
REQ-020 Rising edge of sensor_paso (sensor_paso=1 and registered previous value=0) in ABIERTA_x -> PASANDO; ocupacion +1 for entry, -1 for exit, applied on that same edge; ultimo_salida updated to the served lane.
REQ-021 sensor_paso already high on entry to ABIERTA_x is not a pass; a fresh rising edge is required.
REQ-022 Timer reaching TIMEOUT-1 in ABIERTA_x without a pass -> ALARMA; ocupacion unchanged; ultimo_salida updated to the aborted lane.
REQ-023 Pass edge and timeout on the same cycle: pass wins.
REQ-024 PASANDO: compuerta_abrir=1, grant of served lane held; stays while sensor_paso=1; sensor_paso=0 -> IDLE next edge (barrier never closes on a vehicle).
REQ-025 ALARMA: alarma_timeout=1, compuerta_abrir=0, grants 0, exactly one cycle, then IDLE.
REQ-026 grant_entrada and grant_salida never both high; compuerta_abrir=1 only in ABIERTA_x or PASANDO.
REQ-027 ocupacion never wraps: never exceeds CAPACIDAD, never below 0 (guaranteed by REQ-016; increment/decrement additionally saturate).
REQ-028 Request deassertion during ABIERTA_x or PASANDO is ignored; the grant completes by pass or timeout.
REQ-029 Grant latency: request sampled in IDLE -> grant and compuerta_abrir high from the next cycle.

Reset
REQ-030 reset=1 forces, asynchronously: state IDLE, ocupacion 0, timer 0, ultimo_salida 1, sensor history 0; outputs compuerta_abrir 0, grants 0, alarma_timeout 0, vacio 1, lleno 0 (lleno 1 only if CAPACIDAD==0).
REQ-031 Reset asserted mid-grant or mid-pass aborts immediately with no occupancy update; operation resumes from IDLE on the first edge after release.

Verification
REQ-032 Reset, req_entrada=1, pulse sensor_paso 3 cycles later -> grant_entrada and compuerta_abrir 1 cycle after request, ocupacion 0->1 on the pass edge, gate closes 1 cycle after sensor falls.
REQ-033 Both requests high with ocupacion=5 from reset, pass after each grant -> entry served first, then exit; ocupacion 5->6->5; grants never overlap.
REQ-034 CAPACIDAD=2, fill to 2 -> lleno=1, req_entrada ignored (no grant), req_salida granted; after exit pass lleno=0 and entry granted.
REQ-035 TIMEOUT=8, req_salida with ocupacion=1, no sensor -> grant for 8 cycles, then alarma_timeout one-cycle pulse, gate closed, ocupacion stays 1.
REQ-036 sensor_paso held high before grant -> no count; sensor low then high -> count; reset asserted while in PASANDO -> all outputs to reset values within the same cycle, ocupacion 0.
